// File: rtl/conv_window_engine_pkg.sv
// Shared constants, FSM state encodings and sizing helpers for the
// convolution window engine.
package conv_pkg;

  localparam int DEF_IMG_SIZE  = 16;
  localparam int DEF_FILT_SIZE = 4;
  localparam int DEF_NUM_FILT  = 4;
  localparam int DEF_STRIDE    = 1;
  localparam int DEF_ACC_W     = 20;

  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'd0;
  localparam state_t MAC  = 2'd1;
  localparam state_t EMIT = 2'd2;
  localparam state_t FIN  = 2'd3;

  // Number of window positions along one image side.
  function automatic int out_dim(input int img, input int filt, input int stride);
    return (img - filt) / stride + 1;
  endfunction

  // Smallest accumulator width that holds a full window of 255*255 products.
  function automatic int min_acc_w(input int filt);
    return $clog2(filt * filt * 255 * 255 + 1);
  endfunction

endpackage

// File: rtl/conv_window_engine_mac_unit.sv
// Single-lane 8x8 unsigned multiply-accumulate. The accumulator clears
// synchronously and adds one product per enabled cycle; o_acc_nxt exposes
// the sum including the current product so the caller can capture the
// final window result on the last tap without an extra cycle.
module mac_unit #(
  parameter int ACC_W = 20
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic [7:0]       i_pix,
  input  logic [7:0]       i_tap,
  output logic [ACC_W-1:0] o_acc_nxt
);

  logic [15:0]      w_prod;
  logic [ACC_W-1:0] r_acc;

  assign w_prod    = i_pix * i_tap;
  assign o_acc_nxt = r_acc + ACC_W'(w_prod);

  // Accumulator register: clear wins over enable.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst)     r_acc <= '0;
    else if (i_clr) r_acc <= '0;
    else if (i_en)  r_acc <= o_acc_nxt;
  end

endmodule

// File: rtl/conv_window_engine.sv
// Convolution window engine: slides a FILT_SIZE x FILT_SIZE window over the
// image for each filter, one MAC per cycle, and streams each window sum out
// over valid/ready. Iteration order: filter, then row, then column.
// Build option CONV_SAT8_EN: clamp each result to 0..255 in out_data[7:0].
module conv_window_engine
  import conv_pkg::*;
#(
  parameter int IMG_SIZE  = DEF_IMG_SIZE,
  parameter int FILT_SIZE = DEF_FILT_SIZE,
  parameter int NUM_FILT  = DEF_NUM_FILT,
  parameter int STRIDE    = DEF_STRIDE,
  parameter int ACC_W     = DEF_ACC_W
) (
  input  logic                                   i_clk,
  input  logic                                   i_rst,
  input  logic                                   i_start,
  input  logic [IMG_SIZE*IMG_SIZE*8-1:0]         i_img_data,
  input  logic [NUM_FILT*FILT_SIZE*FILT_SIZE*8-1:0] i_filters,
  output logic                                   o_out_valid,
  input  logic                                   i_out_ready,
  output logic [ACC_W-1:0]                       o_out_data,
  output logic [7:0]                             o_out_filt,
  output logic [7:0]                             o_out_row,
  output logic [7:0]                             o_out_col,
  output logic                                   o_busy,
  output logic                                   o_done
);

  localparam int NTAP    = FILT_SIZE * FILT_SIZE;
  localparam int OUT_DIM = out_dim(IMG_SIZE, FILT_SIZE, STRIDE);
  localparam int KW      = $clog2(NTAP);
  localparam int PW      = $clog2(IMG_SIZE * IMG_SIZE);
  localparam int TW      = $clog2(NUM_FILT * NTAP);

  state_t           r_state;
  logic [KW-1:0]    r_k;
  logic [7:0]       r_filt, r_row, r_col;
  logic [ACC_W-1:0] r_out_data;
  logic [7:0]       r_out_filt, r_out_row, r_out_col;

  logic [PW-1:0]    w_pix_idx;
  logic [TW-1:0]    w_tap_idx;
  logic [7:0]       w_pix, w_tap;
  logic [ACC_W-1:0] w_acc_nxt, w_result;
  logic             w_hs, w_clr, w_last, w_k_last;

  // Pixel and tap addresses for the current (filter, row, col, tap).
  always_comb begin
    w_pix_idx = PW'((int'(r_row) * STRIDE + int'(r_k) / FILT_SIZE) * IMG_SIZE
                    + int'(r_col) * STRIDE + int'(r_k) % FILT_SIZE);
    w_tap_idx = TW'(int'(r_filt) * NTAP + int'(r_k));
  end

  assign w_pix = i_img_data[{w_pix_idx, 3'b000} +: 8];
  assign w_tap = i_filters[{w_tap_idx, 3'b000} +: 8];

  assign w_hs     = (r_state == EMIT) && i_out_ready;
  assign w_clr    = ((r_state == IDLE) && i_start) || w_hs;
  assign w_k_last = (r_k == KW'(NTAP - 1));
  assign w_last   = (r_filt == 8'(NUM_FILT - 1)) && (r_row == 8'(OUT_DIM - 1))
                 && (r_col == 8'(OUT_DIM - 1));

  mac_unit #(.ACC_W(ACC_W)) u_mac (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_clr     (w_clr),
    .i_en      (r_state == MAC),
    .i_pix     (w_pix),
    .i_tap     (w_tap),
    .o_acc_nxt (w_acc_nxt)
  );

`ifdef CONV_SAT8_EN
  assign w_result = (w_acc_nxt > ACC_W'(255)) ? ACC_W'(255) : ACC_W'(w_acc_nxt[7:0]);
`else
  assign w_result = w_acc_nxt;
`endif

  // FSM, window counters and the output holding registers.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state    <= IDLE;
      r_k        <= '0;
      r_filt     <= '0;
      r_row      <= '0;
      r_col      <= '0;
      r_out_data <= '0;
      r_out_filt <= '0;
      r_out_row  <= '0;
      r_out_col  <= '0;
    end else begin
      case (r_state)
        IDLE: if (i_start) r_state <= MAC;
        MAC: begin
          if (w_k_last) begin
            r_k        <= '0;
            r_state    <= EMIT;
            r_out_data <= w_result;
            r_out_filt <= r_filt;
            r_out_row  <= r_row;
            r_out_col  <= r_col;
          end else begin
            r_k <= r_k + KW'(1);
          end
        end
        EMIT: if (i_out_ready) begin
          r_state <= w_last ? FIN : MAC;
          if (r_col == 8'(OUT_DIM - 1)) begin
            r_col <= '0;
            if (r_row == 8'(OUT_DIM - 1)) begin
              r_row  <= '0;
              r_filt <= (r_filt == 8'(NUM_FILT - 1)) ? 8'd0 : r_filt + 8'd1;
            end else begin
              r_row <= r_row + 8'd1;
            end
          end else begin
            r_col <= r_col + 8'd1;
          end
        end
        FIN:     r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_out_valid = (r_state == EMIT);
  assign o_busy      = (r_state != IDLE);
  assign o_done      = (r_state == FIN);
  assign o_out_data  = r_out_data;
  assign o_out_filt  = r_out_filt;
  assign o_out_row   = r_out_row;
  assign o_out_col   = r_out_col;

endmodule

// File: tb/tb_conv_window_engine.sv
// Scoreboard bench for conv_window_engine: expected results are queued when
// a pass is launched; a monitor pops and compares on every handshake.
module tb_conv_window_engine;

  localparam int ACC_W = 20;
  localparam int NRES  = 676;

  logic             clk = 1'b0;
  logic             rst_n, start, out_ready;
  logic [16*16*8-1:0] img;
  logic [4*16*8-1:0]  filt;
  logic             out_valid, busy, done;
  logic [ACC_W-1:0] out_data;
  logic [7:0]       out_filt, out_row, out_col;

  typedef struct { logic [ACC_W-1:0] d; int f; int r; int c; } exp_t;
  exp_t q[$];
  exp_t sb_e;

  int checks = 0, failures = 0, n_acc = 0, done_cnt = 0;

  always #5 clk = ~clk;

  conv_window_engine dut (
    .i_clk(clk), .i_rst(rst_n), .i_start(start),
    .i_img_data(img), .i_filters(filt),
    .o_out_valid(out_valid), .i_out_ready(out_ready), .o_out_data(out_data),
    .o_out_filt(out_filt), .o_out_row(out_row), .o_out_col(out_col),
    .o_busy(busy), .o_done(done)
  );

  // Hand-derived window sums per stimulus pattern.
  //  0: all ones -> 16; 1: all 255 -> 1040400
  //  2: img[i]=i; f0 tap0=1, f1 tap5=2, f2 all ones, f3 tap15=3
  function automatic logic [ACC_W-1:0] exp_val(input int pat, input int f, input int r, input int c);
    int v;
    case (pat)
      0: v = 16;
      1: v = 1040400;
      default: case (f)
        0: v = r * 16 + c;
        1: v = 2 * ((r + 1) * 16 + c + 1);
        2: v = 256 * r + 16 * c + 408;
        default: v = 3 * ((r + 3) * 16 + c + 3);
      endcase
    endcase
`ifdef CONV_SAT8_EN
    if (v > 255) v = 255;
`endif
    return ACC_W'(v);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  task automatic push_pass(input int pat, input int n);
    int k = 0;
    for (int f = 0; f < 4; f++)
      for (int r = 0; r < 13; r++)
        for (int c = 0; c < 13; c++) begin
          exp_t e;
          if (k < n) begin
            e.d = exp_val(pat, f, r, c); e.f = f; e.r = r; e.c = c;
            q.push_back(e);
          end
          k++;
        end
  endtask

  task automatic set_uniform(input logic [7:0] pv, input logic [7:0] tv);
    for (int i = 0; i < 256; i++) img[i*8 +: 8] = pv;
    for (int i = 0; i < 64; i++)  filt[i*8 +: 8] = tv;
  endtask

  // Issue start and check the first result lands in cycle 17 of MAC.
  task automatic start_pass(input string name);
    int cnt = 0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    do begin @(negedge clk); cnt++; end while (!out_valid && cnt < 40);
    chk(name, cnt, 17);
  endtask

  task automatic wait_acc(input int n);
    int cyc = 0;
    while (n_acc < n && cyc < 20000) begin @(negedge clk); cyc++; end
    chk("reach_acc", int'(n_acc >= n), 1);
  endtask

  task automatic finish_pass(input string name);
    int cyc = 0;
    do begin @(negedge clk); cyc++; end while (!done && cyc < 15000);
    chk({name, "_done_seen"}, int'(done), 1);
    chk({name, "_acc_at_done"}, n_acc, NRES);
    repeat (3) @(negedge clk);
    chk({name, "_done_pulses"}, done_cnt, 1);
    chk({name, "_queue_left"}, q.size(), 0);
    chk({name, "_busy_after"}, int'(busy), 0);
    n_acc = 0; done_cnt = 0;
  endtask

  // Monitor: compare every accepted result against the scoreboard head.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) begin
        checks++;
        if (q.size() == 0) begin
          failures++;
          $display("FAIL result_unexpected: got f=%0d r=%0d c=%0d data=%0d required none",
                   out_filt, out_row, out_col, out_data);
        end else begin
          sb_e = q.pop_front();
          if (out_data !== sb_e.d || out_filt !== 8'(sb_e.f) ||
              out_row !== 8'(sb_e.r) || out_col !== 8'(sb_e.c)) begin
            failures++;
            $display("FAIL result[%0d]: got f=%0d r=%0d c=%0d data=%0d required f=%0d r=%0d c=%0d data=%0d",
                     n_acc, out_filt, out_row, out_col, out_data, sb_e.f, sb_e.r, sb_e.c, sb_e.d);
          end
        end
        n_acc++;
      end
      if (done) done_cnt++;
    end
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    rst_n = 1'b0; start = 1'b0; out_ready = 1'b1; img = '0; filt = '0;
    repeat (3) @(posedge clk); #1;
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_data",  int'(out_data), 0);
    chk("rst_busy",  int'(busy), 0);
    chk("rst_done",  int'(done), 0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Pass 0: all ones.
    set_uniform(8'd1, 8'd1);
    push_pass(0, NRES);
    start_pass("lat_ones");
    finish_pass("ones");

    // Pass 1: full-scale pixels and taps.
    set_uniform(8'd255, 8'd255);
    push_pass(1, NRES);
    start_pass("lat_full");
    finish_pass("full");

    // Pass 2: ramp image, distinct filters, with a stall and a stray start.
    for (int i = 0; i < 256; i++) img[i*8 +: 8] = 8'(i);
    filt = '0;
    filt[0*8 +: 8]  = 8'd1;
    filt[21*8 +: 8] = 8'd2;
    for (int i = 32; i < 48; i++) filt[i*8 +: 8] = 8'd1;
    filt[63*8 +: 8] = 8'd3;
    push_pass(2, NRES);
    start_pass("lat_ramp");
    wait_acc(20);
    @(posedge clk); #1 out_ready = 1'b0;
    cnt = 0;
    do begin @(negedge clk); cnt++; end while (!out_valid && cnt < 40);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      chk("stall_valid", int'(out_valid), 1);
      chk("stall_data",  int'(out_data), 23);
      chk("stall_filt",  int'(out_filt), 0);
      chk("stall_row",   int'(out_row), 1);
      chk("stall_col",   int'(out_col), 7);
      chk("stall_no_adv", n_acc, 20);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    @(posedge clk);
    cnt = 0;
    do begin @(negedge clk); cnt++; end while (!out_valid && cnt < 40);
    chk("stall_next_lat", cnt, 17);
    @(posedge clk); #1 start = 1'b1;
    chk("busy_at_stray_start", int'(busy), 1);
    @(posedge clk); #1 start = 1'b0;
    finish_pass("ramp");

    // Pass 3: async reset in the middle of filter 2, then restart.
    set_uniform(8'd1, 8'd1);
    push_pass(0, NRES);
    start_pass("lat_pre_rst");
    wait_acc(341);
    @(posedge clk); #3;
    chk("pre_rst_filt", int'(out_filt), 2);
    chk("pre_rst_busy", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk("arst_valid", int'(out_valid), 0);
    chk("arst_data",  int'(out_data), 0);
    chk("arst_filt",  int'(out_filt), 0);
    chk("arst_row",   int'(out_row), 0);
    chk("arst_col",   int'(out_col), 0);
    chk("arst_busy",  int'(busy), 0);
    chk("arst_done",  int'(done), 0);
    q.delete(); n_acc = 0; done_cnt = 0;
    repeat (2) @(posedge clk); #1 rst_n = 1'b1;
    push_pass(0, 3);
    start_pass("lat_after_rst");
    wait_acc(3);
    chk("restart_queue_left", q.size(), 0);
    @(posedge clk); #1 out_ready = 1'b0;
    repeat (3) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
